// File: rtl/isa_pkg.sv
// Shared ISA constants, immediate-format and loader-state enums for the
// instruction loader and its field packer.
package isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FMT_LOAD    = 2'b00,
    FMT_STORE   = 2'b01,
    FMT_BRANCH  = 2'b10,
    FMT_ILLEGAL = 2'b11
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } ldr_state_e;

  // A 32-bit sign-extended value fits in 12 bits when bits 31..11 all agree.
  function automatic logic imm_fits12(input logic [31:0] imm);
    return (&imm[31:11]) | ~(|imm[31:11]);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: decoded fields -> RV32 I/S/B instruction word,
// plus an illegal flag for bad format or out-of-range immediate.
module instr_field_packer
  import isa_pkg::*;
(
  input  imm_fmt_e    fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [11:0] i12;
  assign i12 = imm[11:0];

  // BRANCH immediates arrive pre-halved, so imm[k] is byte-offset bit k+1.
  always_comb begin
    word    = '0;
    illegal = ~imm_fits12(imm);
    case (fmt)
      FMT_LOAD:    word = {i12, rs1, funct3, rd, OPC_LOAD};
      FMT_STORE:   word = {i12[11:5], rs2, rs1, funct3, i12[4:0], OPC_STORE};
      FMT_BRANCH:  word = {i12[11], i12[9:4], rs2, rs1, funct3, i12[3:0], i12[10], OPC_BRANCH};
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder_loader.sv
// Program loader: packs field beats into RV32 load/store/branch words and
// writes them sequentially into instruction memory, one word per cycle.
module imm_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_limit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic [ERR_W-1:0]  err_count
);

  ldr_state_e        state;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   limit_r;
  logic [31:0]       pk_word;
  logic              pk_illegal;
  logic              accept;
  logic [ADDR_W:0]   wc_inc;

  instr_field_packer u_packer (
    .fmt     (imm_fmt_e'(in_fmt)),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .imm     (in_imm),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  // word_count already includes last cycle's acceptance, so the limit holds.
  assign in_ready = (state == ST_RUN) && (word_count < limit_r);
  assign accept   = in_valid && in_ready;
  assign wc_inc   = word_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      base_r     <= '0;
      limit_r    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            base_r     <= base_addr;
            limit_r    <= word_limit;
            word_count <= '0;
            err        <= 1'b0;
            err_count  <= '0;
            if (word_limit == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (!pk_illegal) begin
              mem_we     <= 1'b1;
              mem_addr   <= base_r + word_count[ADDR_W-1:0];
              mem_wdata  <= pk_word;
              word_count <= wc_inc;
            end else begin
              err <= 1'b1;
              if (err_count != {ERR_W{1'b1}})
                err_count <= err_count + 1'b1;
            end
            if (in_last || (!pk_illegal && (wc_inc == limit_r)))
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
